// File: rtl/bin2bcd_pkg.sv
// Shared types and constants for the sequential binary-to-BCD converter.
package bin2bcd_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SHIFT  = 2'd1,
        FINISH = 2'd2
    } state_t;

    localparam int         BCD_DIGIT_W = 4;
    localparam logic [3:0] BCD_NINE    = 4'h9;
    localparam logic [3:0] ADD3_THRESH = 4'd5;

    // Bit counter must hold the value W itself, hence W+1 codes.
    function automatic int cnt_width(input int w);
        return $clog2(w + 1);
    endfunction

endpackage

// File: rtl/bin2bcd_seq_if.sv
// Start/busy/done handshake and data bundle for bin2bcd_seq.
interface bin2bcd_seq_if #(
    parameter int W      = 8,
    parameter int DIGITS = 3
);
    logic                  start;
    logic [W-1:0]          bin;
    logic                  busy;
    logic                  done;
    logic [4*DIGITS-1:0]   bcd;
    logic                  ovf;

    modport master (
        output start, bin,
        input  busy, done, bcd, ovf
    );

    modport slave (
        input  start, bin,
        output busy, done, bcd, ovf
    );
endinterface

// File: rtl/bin2bcd_seq_add3.sv
// Double-dabble digit correction: add 3 to a BCD digit of 5 or more (4-bit wrap, no carry out).
module bcd_add3
    import bin2bcd_pkg::*;
(
    input  logic [BCD_DIGIT_W-1:0] digit_i,
    output logic [BCD_DIGIT_W-1:0] digit_o
);

    always_comb begin
        digit_o = digit_i;
        if (digit_i >= ADD3_THRESH) begin
            digit_o = digit_i + 4'd3;
        end
    end

endmodule

// File: rtl/bin2bcd_seq.sv
// Sequential shift-add-3 binary-to-BCD converter, one operand bit per clock.
// Optional macro BIN2BCD_SATURATE_EN: overflowing results saturate to all nines with ovf=1.
//
// state  | meaning
// IDLE   | waiting for start
// SHIFT  | add-3 then shift, one bit per cycle, W cycles
// FINISH | one-cycle done pulse, result registers just updated
module bin2bcd_seq
    import bin2bcd_pkg::*;
#(
    parameter int W      = 8,
    parameter int DIGITS = 3
)
(
    input  logic          clk,
    input  logic          rst,
    bin2bcd_seq_if.slave  bus
);

    localparam int BW = BCD_DIGIT_W * DIGITS;
    localparam int CW = cnt_width(W);

    state_t          state_q, state_d;
    logic [W-1:0]    op_q, op_d, op_shift;
    logic [BW-1:0]   scr_q, scr_d, scr_adj, scr_shift;
    logic [BW-1:0]   bcd_q, bcd_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic            last_bit;

`ifdef BIN2BCD_SATURATE_EN
    logic            sticky_q, sticky_d;
    logic            ovf_q, ovf_d;
    logic            ovf_next;
`endif

    for (genvar g = 0; g < DIGITS; g++) begin : g_add3
        bcd_add3 u_add3 (
            .digit_i (scr_q  [g*BCD_DIGIT_W +: BCD_DIGIT_W]),
            .digit_o (scr_adj[g*BCD_DIGIT_W +: BCD_DIGIT_W])
        );
    end

    // Operand MSB moves into scratch bit 0; the scratch MSB falls off the top.
    assign {scr_shift, op_shift} = {scr_adj, op_q} << 1;
    assign last_bit = (cnt_q == CW'(1));

`ifdef BIN2BCD_SATURATE_EN
    assign ovf_next = sticky_q | scr_adj[BW-1];
`endif

    always_comb begin
        state_d  = state_q;
        op_d     = op_q;
        scr_d    = scr_q;
        cnt_d    = cnt_q;
        bcd_d    = bcd_q;
`ifdef BIN2BCD_SATURATE_EN
        sticky_d = sticky_q;
        ovf_d    = ovf_q;
`endif
        case (state_q)
            IDLE, FINISH: begin
                if (bus.start) begin
                    op_d     = bus.bin;
                    scr_d    = '0;
                    cnt_d    = CW'(W);
`ifdef BIN2BCD_SATURATE_EN
                    sticky_d = 1'b0;
`endif
                    state_d  = SHIFT;
                end else if (state_q == FINISH) begin
                    state_d  = IDLE;
                end
            end
            SHIFT: begin
                scr_d    = scr_shift;
                op_d     = op_shift;
                cnt_d    = cnt_q - CW'(1);
`ifdef BIN2BCD_SATURATE_EN
                sticky_d = ovf_next;
`endif
                if (last_bit) begin
                    state_d = FINISH;
`ifdef BIN2BCD_SATURATE_EN
                    ovf_d   = ovf_next;
                    bcd_d   = ovf_next ? {DIGITS{BCD_NINE}} : scr_shift;
`else
                    bcd_d   = scr_shift;
`endif
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            op_q     <= '0;
            scr_q    <= '0;
            cnt_q    <= '0;
            bcd_q    <= '0;
`ifdef BIN2BCD_SATURATE_EN
            sticky_q <= 1'b0;
            ovf_q    <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            op_q     <= op_d;
            scr_q    <= scr_d;
            cnt_q    <= cnt_d;
            bcd_q    <= bcd_d;
`ifdef BIN2BCD_SATURATE_EN
            sticky_q <= sticky_d;
            ovf_q    <= ovf_d;
`endif
        end
    end

    assign bus.busy = (state_q == SHIFT);
    assign bus.done = (state_q == FINISH);
    assign bus.bcd  = bcd_q;
`ifdef BIN2BCD_SATURATE_EN
    assign bus.ovf  = ovf_q;
`else
    assign bus.ovf  = 1'b0;
`endif

endmodule
